// File: rtl/disp_pkg.sv
// Shared constants and elaboration-time helpers for the Viterbi output reorder buffer.
package disp_pkg;

  localparam int unsigned DEFAULT_PIPE_LAT = 133;
  localparam int unsigned DEFAULT_DEPTH    = 32;

  // Ceiling log2, used to size address and counter fields.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_bank_ram.sv
// One reorder bank: synchronous write, registered read, array left unreset.
module disp_bank_ram #(
  parameter int unsigned DW    = 1,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/disp_reorder_buf.sv
// Ping-pong reorder buffer restoring time order after traceback, plus output
// framing (process_en / d_out_valid) and alignment / latency error flags.
module disp_reorder_buf
  import disp_pkg::*;
#(
  parameter int unsigned DW       = 1,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned PIPE_LAT = DEFAULT_PIPE_LAT
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          d_in_valid,
  input  logic          bank_sel,
  input  logic          wr_en,
  input  logic [DW-1:0] d_in,
  output logic          process_en,
  output logic          d_out_valid,
  output logic [DW-1:0] d_out,
  output logic          blk_first,
  output logic          align_err,
  output logic          lat_err
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(PIPE_LAT + 1);
  localparam logic [CW-1:0] LatLoad = CW'(PIPE_LAT - 1);

  logic          active;
  logic [AW-1:0] cnt_q, cnt_d, wr_ptr, rd_ptr;
  logic          bsel_q, rd_bank_q, first_p1_q, din_valid_q, dov_q, pe_clr_q;
  logic [CW-1:0] rise_cnt_q, rise_cnt_d, fall_cnt_q, fall_cnt_d;
  logic          rise_edge, fall_edge, rise_exp, fall_exp;
  logic          dov_d, pe_d, align_d, lat_d;
  logic [DW-1:0] rdata0, rdata1;

  // One shared counter: the write pointer runs backwards as its complement.
  assign active = process_en | d_in_valid;
  assign rd_ptr = cnt_q;
  assign wr_ptr = ~cnt_q;
  assign rise_edge = d_in_valid & ~din_valid_q;
  assign fall_edge = ~d_in_valid & din_valid_q;

  always_comb begin
    cnt_d      = active ? cnt_q + AW'(1) : '0;
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    rise_exp   = 1'b0;
    fall_exp   = 1'b0;
    if (rise_cnt_q != '0) begin
      rise_cnt_d = rise_cnt_q - CW'(1);
      rise_exp   = (rise_cnt_q == CW'(1));
    end else if (rise_edge) begin
      rise_cnt_d = LatLoad;
    end
    if (fall_cnt_q != '0) begin
      fall_cnt_d = fall_cnt_q - CW'(1);
      fall_exp   = (fall_cnt_q == CW'(1));
    end else if (fall_edge) begin
      fall_cnt_d = LatLoad;
    end
    dov_d = d_out_valid;
    if (rise_exp) dov_d = 1'b1;
    if (fall_exp) dov_d = 1'b0;
    pe_d = process_en;
    if (pe_clr_q)   pe_d = 1'b0;
    if (d_in_valid) pe_d = 1'b1;
    // A bank switch is legal only when the new write pointer restarts at DEPTH-1.
    align_d = align_err | ((bank_sel != bsel_q) & (cnt_d != '0));
    lat_d   = lat_err | (rise_edge & (rise_cnt_q != '0)) | (fall_edge & (fall_cnt_q != '0));
  end

  disp_bank_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (wr_en & active & ~bsel_q),
    .waddr (wr_ptr),
    .wdata (d_in),
    .raddr (rd_ptr),
    .rdata (rdata0)
  );

  disp_bank_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (wr_en & active & bsel_q),
    .waddr (wr_ptr),
    .wdata (d_in),
    .raddr (rd_ptr),
    .rdata (rdata1)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q       <= '0;
      bsel_q      <= 1'b0;
      rd_bank_q   <= 1'b0;
      first_p1_q  <= 1'b0;
      blk_first   <= 1'b0;
      d_out       <= '0;
      din_valid_q <= 1'b0;
      rise_cnt_q  <= '0;
      fall_cnt_q  <= '0;
      d_out_valid <= 1'b0;
      dov_q       <= 1'b0;
      pe_clr_q    <= 1'b0;
      process_en  <= 1'b0;
      align_err   <= 1'b0;
      lat_err     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bsel_q      <= bank_sel;
      rd_bank_q   <= ~bsel_q;
      first_p1_q  <= active & (rd_ptr == '0);
      blk_first   <= first_p1_q;
      d_out       <= rd_bank_q ? rdata1 : rdata0;
      din_valid_q <= d_in_valid;
      rise_cnt_q  <= rise_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      d_out_valid <= dov_d;
      dov_q       <= d_out_valid;
      pe_clr_q    <= dov_q & ~d_out_valid;
      process_en  <= pe_d;
      align_err   <= align_d;
      lat_err     <= lat_d;
    end
  end

endmodule
